nes_pad_emulator: RTL and testbench

- Device-side end of the NES controller serial link. It emulates the pad's 4021 parallel-in/serial-out shift register so our FPGA can act as a controller toward a host that drives latch and serial clock and samples data.
- The host-side reader is an existing block. That reader pulses latch, clocks 8 bits, samples on the cclk falling edge, and treats a 0 as pressed, in order A, B, SELECT, START, UP, DOWN, LEFT, RIGHT.
- Latch and cclk arrive asynchronously. They are synchronized into clk and edge-detected.

---
 rtl/nes_pad_emulator.sv | 168 ++++++++++++++++
 tb/tb_nes_pad_emulator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_emulator.sv
// Device-side NES pad: emulates the 4021 PISO shift register toward a host
// that drives latch and a serial clock, both asynchronous to clk.
module nes_pad_emulator #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int NBITS          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             latch_in,
    input  logic             cclk_in,
    input  logic [NBITS-1:0] buttons,
    output logic             data_out,
    output logic             busy,
    output logic             frame_done,
    output logic             timeout_err,
    output logic [15:0]      frame_count
);

    localparam int CNT_W = $clog2(NBITS + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(NBITS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] latch_sync_r;
    logic [SYNC_STAGES-1:0] cclk_sync_r;
    logic                   latch_d_r;
    logic                   cclk_d_r;
    logic                   latch_s;
    logic                   cclk_s;
    logic                   latch_rise_s;
    logic                   latch_fall_s;
    logic                   cclk_rise_s;

    state_t                 state_r;
    state_t                 state_s;
    logic [NBITS-1:0]       shreg_r;
    logic [NBITS-1:0]       shreg_s;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic [CNT_W-1:0]       bit_cnt_s;
    logic [TMO_W-1:0]       tmo_cnt_r;
    logic [TMO_W-1:0]       tmo_cnt_s;
    logic                   frame_done_r;
    logic                   frame_done_s;
    logic                   timeout_err_r;
    logic                   timeout_err_s;
    logic [15:0]            frame_count_r;
    logic [15:0]            frame_count_s;

    assign latch_s      = latch_sync_r[SYNC_STAGES-1];
    assign cclk_s       = cclk_sync_r[SYNC_STAGES-1];
    assign latch_rise_s = latch_s & ~latch_d_r;
    assign latch_fall_s = ~latch_s & latch_d_r;
    assign cclk_rise_s  = cclk_s & ~cclk_d_r;

    // Synchronizer chains and previous-value registers for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_sync_r <= '0;
            cclk_sync_r  <= '0;
            latch_d_r    <= 1'b0;
            cclk_d_r     <= 1'b0;
        end else begin
            latch_sync_r <= {latch_sync_r[SYNC_STAGES-2:0], latch_in};
            cclk_sync_r  <= {cclk_sync_r[SYNC_STAGES-2:0], cclk_in};
            latch_d_r    <= latch_s;
            cclk_d_r     <= cclk_s;
        end
    end

    // Frame FSM state and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            shreg_r       <= '1;
            bit_cnt_r     <= '0;
            tmo_cnt_r     <= '0;
            frame_done_r  <= 1'b0;
            timeout_err_r <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            state_r       <= state_s;
            shreg_r       <= shreg_s;
            bit_cnt_r     <= bit_cnt_s;
            tmo_cnt_r     <= tmo_cnt_s;
            frame_done_r  <= frame_done_s;
            timeout_err_r <= timeout_err_s;
            frame_count_r <= frame_count_s;
        end
    end

    // Next-state logic; latch restarts a frame ahead of shifts and timeout
    always_comb begin
        state_s       = state_r;
        shreg_s       = shreg_r;
        bit_cnt_s     = bit_cnt_r;
        tmo_cnt_s     = tmo_cnt_r;
        frame_done_s  = 1'b0;
        timeout_err_s = 1'b0;
        frame_count_s = frame_count_r;
        case (state_r)
            ST_IDLE: begin
                // Level-sensitive so a latch held across reset release is seen
                if (latch_s) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                shreg_s = ~buttons;
                if (latch_fall_s) begin
                    state_s   = ST_SHIFT;
                    bit_cnt_s = '0;
                    tmo_cnt_s = '0;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_SHIFT: begin
                if (latch_rise_s) begin
                    state_s = ST_LOAD;
                end else if (cclk_rise_s) begin
                    shreg_s   = {shreg_r[NBITS-2:0], 1'b1};
                    bit_cnt_s = bit_cnt_r + CNT_W'(1);
                    tmo_cnt_s = '0;
                    if (bit_cnt_r == BIT_LAST) begin
                        state_s       = ST_IDLE;
                        frame_done_s  = 1'b1;
                        frame_count_s = frame_count_r + 16'd1;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_s       = ST_IDLE;
                    timeout_err_s = 1'b1;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Idle line reads as "nothing pressed"; otherwise present the MSB
    always_comb begin
        data_out = 1'b1;
        if (state_r == ST_IDLE) begin
            data_out = 1'b1;
        end else begin
            data_out = shreg_r[NBITS-1];
        end
    end

    assign busy        = (state_r != ST_IDLE);
    assign frame_done  = frame_done_r;
    assign timeout_err = timeout_err_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_nes_pad_emulator.sv
// Directed bench for nes_pad_emulator: a host model latches, clocks and
// samples data_out on cclk falling edges, checking against hand-derived frames.
module tb_nes_pad_emulator;

    localparam int TIMEOUT = 4096;
    localparam int HALF    = 32;

    logic        clk;
    logic        reset;
    logic        latch_in;
    logic        cclk_in;
    logic [7:0]  buttons;
    logic        data_out;
    logic        busy;
    logic        frame_done;
    logic        timeout_err;
    logic [15:0] frame_count;

    int tests;
    int failed;
    int fd_cnt;
    int to_cnt;

    nes_pad_emulator #(
        .SYNC_STAGES(2),
        .TIMEOUT_CYCLES(TIMEOUT),
        .NBITS(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .latch_in(latch_in),
        .cclk_in(cclk_in),
        .buttons(buttons),
        .data_out(data_out),
        .busy(busy),
        .frame_done(frame_done),
        .timeout_err(timeout_err),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the inactive edge
    always @(negedge clk) begin
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (timeout_err) to_cnt <= to_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_latch(input logic [7:0] b, input int len);
        @(negedge clk);
        buttons  = b;
        latch_in = 1'b1;
        wait_clk(len);
        latch_in = 1'b0;
        wait_clk(4);
    endtask

    // cclk idles high: sample on the fall, the rise shifts the next bit out
    task automatic read_bits(input int n, output logic [15:0] bits);
        bits = 16'd0;
        for (int i = 0; i < n; i++) begin
            cclk_in = 1'b0;
            bits    = {bits[14:0], data_out};
            wait_clk(HALF);
            cclk_in = 1'b1;
            wait_clk(HALF);
        end
    endtask

    initial begin
        logic [15:0] bits;
        int fd0;
        int to0;
        int to_at;

        tests    = 0;
        failed   = 0;
        fd_cnt   = 0;
        to_cnt   = 0;
        reset    = 1'b1;
        latch_in = 1'b1;
        cclk_in  = 1'b1;
        buttons  = 8'h81;
        wait_clk(3);
        check("rst_data_out", 32'(data_out), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        check("rst_frame_count", 32'(frame_count), 32'h0);

        // Latch already high at reset release must still enter LOAD
        reset = 1'b0;
        wait_clk(4);
        check("latch_level_busy", 32'(busy), 32'h1);
        check("latch_level_bitA", 32'(data_out), 32'h0);
        wait_clk(8);
        latch_in = 1'b0;
        wait_clk(4);

        // Nominal frame A+RIGHT
        fd0 = fd_cnt;
        read_bits(8, bits);
        check("nominal_bits", 32'(bits[7:0]), 32'h7E);
        check("nominal_done_cnt", 32'(fd_cnt - fd0), 32'h1);
        check("nominal_frame_count", 32'(frame_count), 32'h1);
        check("nominal_data_after", 32'(data_out), 32'h1);
        check("nominal_busy_after", 32'(busy), 32'h0);

        // Overclock: 12 pulses, extra bits read as 1
        fd0 = fd_cnt;
        do_latch(8'h81, 12);
        read_bits(8, bits);
        check("over_bits", 32'(bits[7:0]), 32'h7E);
        check("over_idle_after8", 32'(busy), 32'h0);
        read_bits(4, bits);
        check("over_extra_bits", 32'(bits[3:0]), 32'hF);
        check("over_done_cnt", 32'(fd_cnt - fd0), 32'h1);
        check("over_frame_count", 32'(frame_count), 32'h2);

        // Re-latch after 3 shifts with START
        fd0 = fd_cnt;
        do_latch(8'h81, 12);
        read_bits(3, bits);
        check("relatch_first3", 32'(bits[2:0]), 32'h3);
        do_latch(8'h10, 12);
        check("relatch_no_done", 32'(fd_cnt - fd0), 32'h0);
        check("relatch_busy", 32'(busy), 32'h1);
        check("relatch_count_held", 32'(frame_count), 32'h2);
        read_bits(8, bits);
        check("relatch_bits", 32'(bits[7:0]), 32'hEF);
        check("relatch_done_cnt", 32'(fd_cnt - fd0), 32'h1);
        check("relatch_frame_count", 32'(frame_count), 32'h3);

        // Timeout: 2 shifts then cclk held high
        to0 = to_cnt;
        to_at = 0;
        do_latch(8'h81, 12);
        read_bits(2, bits);
        for (int i = 1; i <= 5000; i++) begin
            @(negedge clk);
            if (timeout_err && to_at == 0) to_at = i;
        end
        check("timeout_pulse_cnt", 32'(to_cnt - to0), 32'h1);
        check("timeout_pulse_time", 32'(to_at), 32'(TIMEOUT + 3 - HALF));
        check("timeout_data_out", 32'(data_out), 32'h1);
        check("timeout_busy", 32'(busy), 32'h0);
        check("timeout_frame_count", 32'(frame_count), 32'h3);

        // Load window: only the value at the end of the latch is shifted
        @(negedge clk);
        buttons  = 8'h00;
        latch_in = 1'b1;
        wait_clk(4);
        buttons = 8'hFF;
        wait_clk(4);
        buttons = 8'h00;
        wait_clk(4);
        buttons = 8'h40;
        wait_clk(6);
        latch_in = 1'b0;
        wait_clk(4);
        buttons = 8'hFF;
        read_bits(8, bits);
        check("loadwin_bits", 32'(bits[7:0]), 32'hBF);
        check("loadwin_frame_count", 32'(frame_count), 32'h4);

        // Asynchronous reset after 4 shifts
        do_latch(8'h81, 12);
        read_bits(4, bits);
        reset = 1'b1;
        #1;
        check("midrst_data_out", 32'(data_out), 32'h1);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_frame_count", 32'(frame_count), 32'h0);
        wait_clk(2);
        reset = 1'b0;
        wait_clk(2);

        // cclk toggling during latch must not shift
        @(negedge clk);
        buttons  = 8'h01;
        latch_in = 1'b1;
        wait_clk(6);
        for (int i = 0; i < 4; i++) begin
            cclk_in = 1'b0;
            wait_clk(8);
            cclk_in = 1'b1;
            wait_clk(8);
        end
        wait_clk(6);
        latch_in = 1'b0;
        wait_clk(4);
        read_bits(8, bits);
        check("load_cclk_bits", 32'(bits[7:0]), 32'hFE);
        check("load_cclk_frame_count", 32'(frame_count), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
